expr_eval: RTL and testbench
============================

// Module: expr_eval
// PURPOSE
//  Downstream consumer of the expression character stream ("digit (op digit)*", op in {'+','*'}).
//  Evaluates the expression with '*' binding tighter than '+', one char per accepted cycle.
//  Char '=' terminates an expression; block reports value or syntax error, then restarts.
//  Sits after the expression-syntax recogniser on the same 8-bit ASCII bus.
// PARAMETERS
//  WIDTH  16  result/accumulator width; all arithmetic modulo 2^WIDTH
// PORTS
//  clk           in   1      single clock, rising edge
//  clr_n         in   1      reset, asynchronous, active-low
//  in            in   8      ASCII character
//  in_valid      in   1      char on `in` consumed this cycle when 1
//  result        out  WIDTH  value of last terminated expression
//  result_valid  out  1      one-cycle pulse: result/err updated
//  err           out  1      last terminated expression was malformed
//  busy          out  1      expression in progress (>=1 char accepted since last '=')
// BEHAVIOUR
//  Reset (clr_n=0, async): state=S_NUM, sum=0, prod=1, num=0, result=0, result_valid=0, err=0, busy=0.
//  Reset mid-expression discards all partial state; no result_valid is emitted.
//  in_valid=0: nothing changes; result_valid drops to 0.
//  States: S_NUM (expect digit), S_OP (digit seen, expect op/'='), S_ERR (malformed, wait '=').
//  S_NUM: digit d -> num=d, go S_OP; '=' -> error termination; other -> S_ERR.
//  S_OP: '*' -> prod=prod*num, go S_NUM; '+' -> sum=sum+prod*num, prod=1, go S_NUM;
//        '=' -> result=sum+prod*num, err=0, pulse; digit -> see CONFIGURATION; other -> S_ERR.
//  S_ERR: ignore all chars except '=' -> error termination.
//  Error termination: result=0, err=1, result_valid pulse.
//  Every termination: sum=0, prod=1, num=0, state=S_NUM, busy=0.
//  Latency: result/err/result_valid registered, visible the cycle after '=' is accepted.
//  result and err hold until next termination; result_valid high exactly 1 cycle per '='.
//  Products/sums truncated to WIDTH bits (wrap, no overflow flag).
//  busy=1 from cycle after first accepted non-'=' char until cycle after terminating '='.
//  Back-to-back expressions: char following '=' is first char of new expression, no gap.
// CONFIGURATION
//  MULTI_DIGIT_EN defined: digit in S_OP -> num=num*10+d (mod 2^WIDTH), stay S_OP.
//  MULTI_DIGIT_EN undefined: digit in S_OP -> S_ERR (single-digit operands only).
// STRUCTURE
//  Package expr_pkg: state encoding (S_NUM,S_OP,S_ERR), ASCII constants CH_0,CH_9,CH_ADD,CH_MUL,CH_EQ.
//  Sub-module expr_char_class: combinational decode of `in` -> is_digit, digit[3:0], is_add, is_mul, is_eq.
//  Top: FSM + sum/prod/num datapath + output registers.
// TESTING
//  "1+2*3=" -> result=7, err=0, one result_valid pulse 1 cycle after '='.
//  "2*3+4*5=" then "9=" back-to-back -> 26 then 9, two pulses, no gap needed.
//  "1++2=" and lone "=" -> err=1, result=0 each; next "3*3=" -> 9, err=0.
//  "12*3=": with MULTI_DIGIT_EN -> 36; without -> err=1.
//  WIDTH=8, "9*9*9=" -> 217 (729 mod 256); in_valid gaps mid-expression do not alter result.
//  clr_n low during "5*" then "4=" -> 4, err=0; no pulse during reset; outputs at reset values.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared state encoding and ASCII constants for the expression evaluator.
package expr_pkg;

   typedef enum logic [1:0] {
      S_NUM = 2'd0,
      S_OP  = 2'd1,
      S_ERR = 2'd2
   } state_e;

   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;
   localparam logic [7:0] CH_ADD = 8'h2B;
   localparam logic [7:0] CH_MUL = 8'h2A;
   localparam logic [7:0] CH_EQ  = 8'h3D;

endpackage

// File: rtl/expr_char_class.sv
// Combinational classification of one ASCII character for the evaluator.
module expr_char_class
   import expr_pkg::*;
(
   input  logic [7:0] ch_i,
   output logic       is_digit_o,
   output logic [3:0] digit_o,
   output logic       is_add_o,
   output logic       is_mul_o,
   output logic       is_eq_o
);

   // The low nibble of '0'..'9' is the digit value itself.
   assign is_digit_o = (ch_i >= CH_0) && (ch_i <= CH_9);
   assign digit_o    = ch_i[3:0];
   assign is_add_o   = (ch_i == CH_ADD);
   assign is_mul_o   = (ch_i == CH_MUL);
   assign is_eq_o    = (ch_i == CH_EQ);

endmodule

// File: rtl/expr_eval.sv
// Streaming "digit (op digit)*=" evaluator with '*' above '+', modulo 2^WIDTH.
// Define MULTI_DIGIT_EN to accept multi-digit decimal operands.
module expr_eval
   import expr_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [7:0]       in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             err,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef MULTI_DIGIT_EN
   localparam logic [WIDTH-1:0] TEN = WIDTH'(4'd10);
`endif

   logic             is_digit_s;
   logic [3:0]       digit_s;
   logic             is_add_s;
   logic             is_mul_s;
   logic             is_eq_s;
   logic [WIDTH-1:0] digit_ext_s;
   logic [WIDTH-1:0] term_s;
   logic [WIDTH-1:0] total_s;

   state_e           state_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] prod_q;
   logic [WIDTH-1:0] num_q;
   logic [WIDTH-1:0] result_q;
   logic             result_valid_q;
   logic             err_q;
   logic             busy_q;

   expr_char_class u_class (
      .ch_i       (in),
      .is_digit_o (is_digit_s),
      .digit_o    (digit_s),
      .is_add_o   (is_add_s),
      .is_mul_o   (is_mul_s),
      .is_eq_o    (is_eq_s)
   );

   // term_s is the pending product including the current operand.
   assign digit_ext_s = {{(WIDTH-4){1'b0}}, digit_s};
   assign term_s      = prod_q * num_q;
   assign total_s     = sum_q + term_s;

   // Parser FSM, sum/product datapath and registered outputs.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q        <= S_NUM;
         sum_q          <= '0;
         prod_q         <= ONE;
         num_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         if (in_valid) begin
            if (is_eq_s) begin
               result_valid_q <= 1'b1;
               busy_q         <= 1'b0;
               sum_q          <= '0;
               prod_q         <= ONE;
               num_q          <= '0;
               state_q        <= S_NUM;
               if (state_q == S_OP) begin
                  result_q <= total_s;
                  err_q    <= 1'b0;
               end else begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end
            end else begin
               busy_q <= 1'b1;
               case (state_q)
                  S_NUM: begin
                     if (is_digit_s) begin
                        num_q   <= digit_ext_s;
                        state_q <= S_OP;
                     end else begin
                        state_q <= S_ERR;
                     end
                  end
                  S_OP: begin
                     if (is_mul_s) begin
                        prod_q  <= term_s;
                        state_q <= S_NUM;
                     end else if (is_add_s) begin
                        sum_q   <= total_s;
                        prod_q  <= ONE;
                        state_q <= S_NUM;
                     end else if (is_digit_s) begin
`ifdef MULTI_DIGIT_EN
                        num_q   <= num_q * TEN + digit_ext_s;
                        state_q <= S_OP;
`else
                        state_q <= S_ERR;
`endif
                     end else begin
                        state_q <= S_ERR;
                     end
                  end
                  S_ERR:   state_q <= S_ERR;
                  default: state_q <= S_ERR;
               endcase
            end
         end
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign err          = err_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a WIDTH=16 and a WIDTH=8 instance share one character stream.
module tb_expr_eval;

   logic        clk;
   logic        clr_n;
   logic [7:0]  in;
   logic        in_valid;
   logic [15:0] res16;
   logic        rv16, err16, busy16;
   logic [7:0]  res8;
   logic        rv8, err8, busy8;

   int n_tests = 0;
   int n_fail  = 0;

   expr_eval #(.WIDTH(16)) u16 (
      .clk(clk), .clr_n(clr_n), .in(in), .in_valid(in_valid),
      .result(res16), .result_valid(rv16), .err(err16), .busy(busy16)
   );

   expr_eval #(.WIDTH(8)) u8 (
      .clk(clk), .clr_n(clr_n), .in(in), .in_valid(in_valid),
      .result(res8), .result_valid(rv8), .err(err8), .busy(busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one char for one cycle; returns #1 after the accepting edge.
   task automatic send(input byte c);
      @(negedge clk);
      in       = c;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in       = 8'h00;
      @(posedge clk);
      #1;
   endtask

   task automatic check_term(input string tag, input logic [15:0] e16, input logic [7:0] e8,
                             input logic e_err);
      check({tag, "_rv16"}, {31'd0, rv16}, 32'd1);
      check({tag, "_res16"}, {16'd0, res16}, {16'd0, e16});
      check({tag, "_err16"}, {31'd0, err16}, {31'd0, e_err});
      check({tag, "_busy16"}, {31'd0, busy16}, 32'd0);
      check({tag, "_rv8"}, {31'd0, rv8}, 32'd1);
      check({tag, "_res8"}, {24'd0, res8}, {24'd0, e8});
      check({tag, "_err8"}, {31'd0, err8}, {31'd0, e_err});
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   initial begin
      clr_n    = 1'b0;
      in       = 8'h00;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_res", {16'd0, res16}, 32'd0);
      check("rst_rv", {31'd0, rv16}, 32'd0);
      check("rst_err", {31'd0, err16}, 32'd0);
      check("rst_busy", {31'd0, busy16}, 32'd0);
      @(negedge clk);
      clr_n = 1'b1;

      // 1+2*3 = 7
      send("1");
      check("busy_first", {31'd0, busy16}, 32'd1);
      send_str("+2*3");
      check("no_pulse_mid", {31'd0, rv16}, 32'd0);
      send("=");
      check_term("e1", 16'd7, 8'd7, 1'b0);
      idle();
      check("pulse_one_cycle", {31'd0, rv16}, 32'd0);
      check("result_hold", {16'd0, res16}, 32'd7);

      // 2*3+4*5 = 26, then 9 = 9 back-to-back
      send_str("2*3+4*5=");
      check_term("e2", 16'd26, 8'd26, 1'b0);
      send("9");
      check("b2b_rv_drop", {31'd0, rv16}, 32'd0);
      check("b2b_busy", {31'd0, busy16}, 32'd1);
      send("=");
      check_term("e3", 16'd9, 8'd9, 1'b0);

      // malformed and lone '='
      send_str("1++2=");
      check_term("e4", 16'd0, 8'd0, 1'b1);
      idle();
      send("=");
      check_term("e5", 16'd0, 8'd0, 1'b1);
      send_str("3*3=");
      check_term("e6", 16'd9, 8'd9, 1'b0);

      // multi-digit operand
      send_str("12*3=");
`ifdef MULTI_DIGIT_EN
      check_term("e7", 16'd36, 8'd36, 1'b0);
`else
      check_term("e7", 16'd0, 8'd0, 1'b1);
`endif

      // 9*9*9 with gaps: 729, and 217 on the 8-bit instance
      send("9");
      idle();
      check("gap_rv", {31'd0, rv16}, 32'd0);
      idle();
      send("*");
      idle();
      send_str("9*");
      idle();
      send_str("9=");
      check_term("e8", 16'd729, 8'd217, 1'b0);

      // reset mid-expression
      send_str("5*");
      @(negedge clk);
      in_valid = 1'b0;
      clr_n    = 1'b0;
      #1;
      check("midrst_res", {16'd0, res16}, 32'd0);
      check("midrst_err", {31'd0, err16}, 32'd0);
      check("midrst_busy", {31'd0, busy16}, 32'd0);
      check("midrst_rv", {31'd0, rv16}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("midrst_rv_hold", {31'd0, rv16}, 32'd0);
      @(negedge clk);
      clr_n = 1'b1;
      send_str("4=");
      check_term("e9", 16'd4, 8'd4, 1'b0);
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
